vga_sync_gen: RTL and testbench
===============================

VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

Interface
- REQ-001 SHALL: parameter TOTAL_COLS, default 800, horizontal pixels per line including blanking.
- REQ-002 SHALL: parameter TOTAL_ROWS, default 525, lines per frame including blanking.
- REQ-003 SHALL: parameter ACTIVE_COLS, default 640, visible pixels per line.
- REQ-004 SHALL: parameter ACTIVE_ROWS, default 480, visible lines per frame.
- REQ-005 SHALL: parameter H_FRONT_PORCH, default 16; parameter H_SYNC_WIDTH, default 96, both in pixels.
- REQ-006 SHALL: parameter V_FRONT_PORCH, default 10; parameter V_SYNC_WIDTH, default 2, both in lines.
- REQ-007 SHALL: i_Clk  input  1  pixel clock, 25 MHz nominal; all state on rising edge.
- REQ-008 SHALL: i_Rst_L  input  1  reset, asynchronous, active-low.
- REQ-009 SHALL: i_Enable  input  1  high = timing advances; low = all state holds.
- REQ-010 SHALL: o_Col_Count  output  10  current column, 0..TOTAL_COLS-1.
- REQ-011 SHALL: o_Row_Count  output  10  current row, 0..TOTAL_ROWS-1.
- REQ-012 SHALL: o_HSync  output  1  horizontal sync, active-low.
- REQ-013 SHALL: o_VSync  output  1  vertical sync, active-low.
- REQ-014 SHALL: o_Active  output  1  high when col < ACTIVE_COLS and row < ACTIVE_ROWS.
- REQ-015 SHALL: o_Frame_Start  output  1  single-cycle pulse while col = 0 and row = 0.

Function
- REQ-016 SHALL: all outputs registered; every decoded output describes the col/row value presented in the same cycle (zero skew between counts and decodes).
- REQ-017 SHALL: with i_Enable high, col increments by 1 each cycle; at TOTAL_COLS-1 col wraps to 0 and row increments by 1.
- REQ-018 SHALL: row wraps from TOTAL_ROWS-1 to 0 on the same cycle col wraps from TOTAL_COLS-1 (frame boundary).
- REQ-019 SHALL: o_HSync low iff ACTIVE_COLS+H_FRONT_PORCH <= col < ACTIVE_COLS+H_FRONT_PORCH+H_SYNC_WIDTH (defaults 656..751).
- REQ-020 SHALL: o_VSync low iff ACTIVE_ROWS+V_FRONT_PORCH <= row < ACTIVE_ROWS+V_FRONT_PORCH+V_SYNC_WIDTH (defaults 490..491), for the full line width.
- REQ-021 SHALL: o_Frame_Start high for exactly one cycle per frame; it stays high while i_Enable is low at position (0,0) but reasserts only once per frame.
- REQ-022 SHALL: i_Enable low freezes counts and all decoded outputs at current values; advance resumes the cycle after i_Enable returns high.
- REQ-023 SHALL: counter arithmetic in 10 bits; col/row never exceed TOTAL_COLS-1 / TOTAL_ROWS-1 at any time.

Reset
- REQ-024 SHALL: while i_Rst_L low, o_Col_Count=0, o_Row_Count=0, o_HSync=1, o_VSync=1, o_Active=1, o_Frame_Start=1 (state for position 0,0).
- REQ-025 SHALL: reset assertion mid-frame takes effect immediately, independent of i_Clk; first advance to col 1 occurs on the first rising edge with i_Rst_L high and i_Enable high.

Configuration
- REQ-026 SHALL: macro VGA_SYNC_FRAME_CNT_EN defined adds output o_Frame_Count (8 bits), reset 0, incremented on each frame-boundary wrap (REQ-018), wrapping 255 -> 0, held when i_Enable low.
- REQ-027 SHALL: macro VGA_SYNC_FRAME_CNT_EN undefined removes the o_Frame_Count port and its register; all other behaviour identical.

Verification
- REQ-028 SHALL: release reset, i_Enable high, 800 cycles -> col sequence 0..799 then 0, row 0 -> 1 at that wrap.
- REQ-029 SHALL: run one line -> o_HSync low exactly at col 656..751 (96 cycles), high elsewhere; o_Active low from col 640.
- REQ-030 SHALL: run one full frame (420000 cycles) -> o_VSync low for rows 490..491 (1600 cycles), o_Frame_Start pulses at cycle 0 and 420000 only.
- REQ-031 SHALL: drop i_Enable at col 300 row 100 for 50 cycles -> all outputs frozen, next edge after re-enable gives col 301.
- REQ-032 SHALL: assert i_Rst_L low asynchronously at col 700 row 491 -> outputs reach reset values (REQ-024) before the next clock edge.
- REQ-033 SHALL: with VGA_SYNC_FRAME_CNT_EN, run 257 frames -> o_Frame_Count reaches 255 then wraps to 0 then 1.

Source files
------------

// File: rtl/vga_sync_gen.sv
// VGA timing generator: registered column/row counters with zero-skew sync, active and frame-start decodes.
// Optional macro VGA_SYNC_FRAME_CNT_EN adds an 8-bit o_Frame_Count output.
module vga_sync_gen #(
  parameter int TOTAL_COLS    = 800,
  parameter int TOTAL_ROWS    = 525,
  parameter int ACTIVE_COLS   = 640,
  parameter int ACTIVE_ROWS   = 480,
  parameter int H_FRONT_PORCH = 16,
  parameter int H_SYNC_WIDTH  = 96,
  parameter int V_FRONT_PORCH = 10,
  parameter int V_SYNC_WIDTH  = 2
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       i_Enable,
  output logic [9:0] o_Col_Count,
  output logic [9:0] o_Row_Count,
  output logic       o_HSync,
  output logic       o_VSync,
  output logic       o_Active,
  output logic       o_Frame_Start
`ifdef VGA_SYNC_FRAME_CNT_EN
  ,
  output logic [7:0] o_Frame_Count
`endif
);

  localparam logic [9:0] L_COL_MAX  = 10'(TOTAL_COLS - 1);
  localparam logic [9:0] L_ROW_MAX  = 10'(TOTAL_ROWS - 1);
  localparam logic [9:0] L_ACT_COLS = 10'(ACTIVE_COLS);
  localparam logic [9:0] L_ACT_ROWS = 10'(ACTIVE_ROWS);
  localparam logic [9:0] L_HS_START = 10'(ACTIVE_COLS + H_FRONT_PORCH);
  localparam logic [9:0] L_HS_END   = 10'(ACTIVE_COLS + H_FRONT_PORCH + H_SYNC_WIDTH);
  localparam logic [9:0] L_VS_START = 10'(ACTIVE_ROWS + V_FRONT_PORCH);
  localparam logic [9:0] L_VS_END   = 10'(ACTIVE_ROWS + V_FRONT_PORCH + V_SYNC_WIDTH);

  logic [9:0] r_Col;
  logic [9:0] r_Row;
  logic       r_HSync;
  logic       r_VSync;
  logic       r_Active;
  logic       r_Frame_Start;

  logic       w_Col_Wrap;
  logic       w_Row_Wrap;
  logic [9:0] w_Next_Col;
  logic [9:0] w_Next_Row;

  always_comb begin
    w_Col_Wrap = (r_Col == L_COL_MAX);
    w_Row_Wrap = (r_Row == L_ROW_MAX);
    w_Next_Col = w_Col_Wrap ? 10'd0 : r_Col + 10'd1;
    w_Next_Row = r_Row;
    if (w_Col_Wrap) begin
      w_Next_Row = w_Row_Wrap ? 10'd0 : r_Row + 10'd1;
    end
  end

  // Decodes are computed from the next position so they land in the same cycle as the counts.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_Col         <= 10'd0;
      r_Row         <= 10'd0;
      r_HSync       <= 1'b1;
      r_VSync       <= 1'b1;
      r_Active      <= 1'b1;
      r_Frame_Start <= 1'b1;
    end else if (i_Enable) begin
      r_Col         <= w_Next_Col;
      r_Row         <= w_Next_Row;
      r_HSync       <= !((w_Next_Col >= L_HS_START) && (w_Next_Col < L_HS_END));
      r_VSync       <= !((w_Next_Row >= L_VS_START) && (w_Next_Row < L_VS_END));
      r_Active      <= (w_Next_Col < L_ACT_COLS) && (w_Next_Row < L_ACT_ROWS);
      r_Frame_Start <= (w_Next_Col == 10'd0) && (w_Next_Row == 10'd0);
    end
  end

`ifdef VGA_SYNC_FRAME_CNT_EN
  logic [7:0] r_Frame_Count;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_Frame_Count <= 8'd0;
    end else if (i_Enable && w_Col_Wrap && w_Row_Wrap) begin
      r_Frame_Count <= r_Frame_Count + 8'd1;
    end
  end

  assign o_Frame_Count = r_Frame_Count;
`endif

  assign o_Col_Count   = r_Col;
  assign o_Row_Count   = r_Row;
  assign o_HSync       = r_HSync;
  assign o_VSync       = r_VSync;
  assign o_Active      = r_Active;
  assign o_Frame_Start = r_Frame_Start;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Self-checking bench for vga_sync_gen using a reduced 20x12 timing so whole frames fit in a short run.
// Frame-count checks are compiled in when VGA_SYNC_FRAME_CNT_EN is defined.
module tb_vga_sync_gen;

  localparam int TC  = 20;
  localparam int TR  = 12;
  localparam int AC  = 12;
  localparam int AR  = 8;
  localparam int HFP = 2;
  localparam int HSW = 3;
  localparam int VFP = 1;
  localparam int VSW = 2;

  logic       clk = 1'b0;
  logic       rstL = 1'b0;
  logic       en = 1'b0;
  logic [9:0] col;
  logic [9:0] row;
  logic       hs;
  logic       vs;
  logic       act;
  logic       fs;
`ifdef VGA_SYNC_FRAME_CNT_EN
  logic [7:0] fcnt;
`endif

  typedef struct packed {
    logic [9:0] col;
    logic [9:0] row;
    logic       hs;
    logic       vs;
    logic       act;
    logic       fs;
    logic [7:0] frames;
  } exp_t;

  typedef struct {
    logic en;
    int   cycles;
    int   expCol;
    int   expRow;
  } vec_t;

  exp_t sbQ[$];
  int   checks = 0;
  int   errors = 0;
  int   mCol = 0;
  int   mRow = 0;
  int   mFrames = 0;

  vga_sync_gen #(
    .TOTAL_COLS(TC), .TOTAL_ROWS(TR), .ACTIVE_COLS(AC), .ACTIVE_ROWS(AR),
    .H_FRONT_PORCH(HFP), .H_SYNC_WIDTH(HSW), .V_FRONT_PORCH(VFP), .V_SYNC_WIDTH(VSW)
  ) dut (
    .i_Clk(clk),
    .i_Rst_L(rstL),
    .i_Enable(en),
    .o_Col_Count(col),
    .o_Row_Count(row),
    .o_HSync(hs),
    .o_VSync(vs),
    .o_Active(act),
    .o_Frame_Start(fs)
`ifdef VGA_SYNC_FRAME_CNT_EN
    ,
    .o_Frame_Count(fcnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic exp_t predict();
    exp_t e;
    e.col    = 10'(mCol);
    e.row    = 10'(mRow);
    e.hs     = !((mCol >= AC + HFP) && (mCol < AC + HFP + HSW));
    e.vs     = !((mRow >= AR + VFP) && (mRow < AR + VFP + VSW));
    e.act    = (mCol < AC) && (mRow < AR);
    e.fs     = (mCol == 0) && (mRow == 0);
    e.frames = 8'(mFrames);
    return e;
  endfunction

  task automatic checkVal(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic checkOutput(input string name);
    exp_t e;
    exp_t a;
    checks++;
    if (sbQ.size() == 0) begin
      errors++;
      $display("[TB] FAIL %s: got empty scoreboard, expected a queued entry", name);
    end else begin
      e = sbQ.pop_front();
      a = {col, row, hs, vs, act, fs, 8'd0};
`ifdef VGA_SYNC_FRAME_CNT_EN
      a.frames = fcnt;
`else
      e.frames = 8'd0;
`endif
      if (a !== e) begin
        errors++;
        $display("[TB] FAIL %s: got col=%0d row=%0d hs=%b vs=%b act=%b fs=%b fc=%0d, expected col=%0d row=%0d hs=%b vs=%b act=%b fs=%b fc=%0d",
                 name, a.col, a.row, a.hs, a.vs, a.act, a.fs, a.frames,
                 e.col, e.row, e.hs, e.vs, e.act, e.fs, e.frames);
      end
    end
  endtask

  task automatic applyStimulus(input logic e);
    en = e;
    if (e) begin
      mCol++;
      if (mCol == TC) begin
        mCol = 0;
        mRow++;
        if (mRow == TR) begin
          mRow = 0;
          mFrames = (mFrames + 1) % 256;
        end
      end
    end
    sbQ.push_back(predict());
    @(posedge clk);
    @(negedge clk);
    checkOutput("scoreboard");
  endtask

  initial begin
    vec_t vecs[7];
    int   fsSeen;

    vecs[0] = '{1'b1, 19, 19, 0};
    vecs[1] = '{1'b1, 1, 0, 1};
    vecs[2] = '{1'b0, 5, 0, 1};
    vecs[3] = '{1'b1, 63, 3, 4};
    vecs[4] = '{1'b1, 157, 0, 0};
    vecs[5] = '{1'b0, 3, 0, 0};
    vecs[6] = '{1'b1, 1, 1, 0};

    repeat (2) @(negedge clk);
    sbQ.push_back(predict());
    checkOutput("reset_state");
    @(negedge clk);
    rstL = 1'b1;
    sbQ.push_back(predict());
    checkOutput("after_release");

    for (int i = 0; i < 7; i++) begin
      for (int c = 0; c < vecs[i].cycles; c++) applyStimulus(vecs[i].en);
      checkVal($sformatf("vec%0d_col", i), int'(col), vecs[i].expCol);
      checkVal($sformatf("vec%0d_row", i), int'(row), vecs[i].expRow);
    end

    // Two full frames from (1,0): frame start must be seen exactly twice.
    fsSeen = 0;
    for (int c = 0; c < 2 * TC * TR; c++) begin
      applyStimulus(1'b1);
      if (fs) fsSeen++;
    end
    checkVal("frame_start_pulses", fsSeen, 2);

    for (int c = 0; c < 66; c++) applyStimulus(1'b1);
    checkVal("pre_hold_col", int'(col), 7);
    for (int c = 0; c < 5; c++) applyStimulus(1'b0);
    checkVal("hold_col", int'(col), 7);
    applyStimulus(1'b1);
    checkVal("resume_col", int'(col), 8);

    // Land on col 16 row 10, inside both sync pulses, then reset between edges.
    for (int c = 0; c < 148; c++) applyStimulus(1'b1);
    checkVal("pre_reset_col", int'(col), 16);
    checkVal("pre_reset_row", int'(row), 10);
    #2;
    rstL = 1'b0;
    mCol = 0;
    mRow = 0;
    mFrames = 0;
    #1;
    sbQ.push_back(predict());
    checkOutput("async_reset");
    @(posedge clk);
    @(negedge clk);
    sbQ.push_back(predict());
    checkOutput("reset_held");
    rstL = 1'b1;
    applyStimulus(1'b1);
    checkVal("first_advance_col", int'(col), 1);

`ifdef VGA_SYNC_FRAME_CNT_EN
    for (int c = 0; c < 257 * TC * TR - 1; c++) applyStimulus(1'b1);
    checkVal("frame_count_wrap", int'(fcnt), 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
